// File: rtl/dromajo_trace_pkg.sv
// Shared types for the Dromajo trace queue: one buffered retire/trap record.
package dromajo_trace_pkg;

  localparam int INST_LEN   = 32;
  localparam int HARTID_LEN = 32;
  // Field width of the stored record; the queue's XLEN parameter must match it.
  localparam int TRACE_XLEN = 64;

  typedef struct packed {
    logic                  is_trap;
    logic [TRACE_XLEN-1:0] pc;
    logic [INST_LEN-1:0]   inst;
    logic [TRACE_XLEN-1:0] wdata;
    logic [TRACE_XLEN-1:0] mstatus;
    logic                  check;
    logic [TRACE_XLEN-1:0] cause;
  } trace_entry_t;

endpackage

// File: rtl/dromajo_lane_compactor.sv
// Prefix-sum over the retire valids: each valid lane gets its slot offset,
// and the trap record lands right after the last valid lane.
module dromajo_lane_compactor #(
  parameter int COMMIT_WIDTH = 3,
  parameter int OFF_W        = $clog2(COMMIT_WIDTH + 2)
) (
  input  logic [COMMIT_WIDTH-1:0]            lane_valid_i,
  output logic [COMMIT_WIDTH-1:0][OFF_W-1:0] lane_off_o,
  output logic [OFF_W-1:0]                   n_o,
  output logic [OFF_W-1:0]                   trap_off_o
);

  logic [OFF_W-1:0] acc;

  always_comb begin
    acc        = '0;
    lane_off_o = '0;
    for (int i = 0; i < COMMIT_WIDTH; i++) begin
      lane_off_o[i] = acc;
      acc           = acc + OFF_W'(lane_valid_i[i]);
    end
    n_o        = acc;
    trap_off_o = acc;
  end

endmodule

// File: rtl/dromajo_trace_queue.sv
// Retire-bundle FIFO feeding the Dromajo checker: compacts valid lanes, appends
// the cycle's trap after them, and drains one record per cycle over valid/ready.
module dromajo_trace_queue
  import dromajo_trace_pkg::*;
#(
  parameter int COMMIT_WIDTH = 3,
  parameter int XLEN         = 64,
  parameter int DEPTH        = 16
) (
  input  logic                         clock,
  input  logic                         reset,
  input  logic [HARTID_LEN-1:0]        hartid,
  input  logic [COMMIT_WIDTH-1:0]      in_valid,
  input  logic [XLEN*COMMIT_WIDTH-1:0] in_pc,
  input  logic [INST_LEN*COMMIT_WIDTH-1:0] in_inst,
  input  logic [XLEN*COMMIT_WIDTH-1:0] in_wdata,
  input  logic [XLEN*COMMIT_WIDTH-1:0] in_mstatus,
  input  logic [COMMIT_WIDTH-1:0]      in_check,
  input  logic                         in_int_xcpt,
  input  logic [XLEN-1:0]              in_cause,
  output logic                         out_valid,
  input  logic                         out_ready,
  output logic                         out_is_trap,
  output logic [XLEN-1:0]              out_pc,
  output logic [XLEN-1:0]              out_wdata,
  output logic [XLEN-1:0]              out_mstatus,
  output logic [XLEN-1:0]              out_cause,
  output logic [INST_LEN-1:0]          out_inst,
  output logic                         out_check,
  output logic [HARTID_LEN-1:0]        out_hartid,
  output logic [$clog2(DEPTH):0]       count,
  output logic                         almost_full,
  output logic                         overflow
);

  // Handshake: the head record transfers on a clock edge where out_valid && out_ready.
  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam int OFF_W = $clog2(COMMIT_WIDTH + 2);

  logic [PTR_W-1:0]      wr_q, wr_d, rd_q, rd_d;
  logic [CNT_W-1:0]      count_q, count_d;
  logic                  overflow_q, overflow_d;
  logic [HARTID_LEN-1:0] hartid_q;
  trace_entry_t          mem_q [DEPTH];

  logic [COMMIT_WIDTH-1:0][OFF_W-1:0] lane_off;
  logic [OFF_W-1:0]                   n_commit, trap_off;
  logic [CNT_W-1:0]                   need, free_slots;
  logic                               accept, pop;
  trace_entry_t                       lane_entry [COMMIT_WIDTH];
  trace_entry_t                       trap_entry, head;

  dromajo_lane_compactor #(
    .COMMIT_WIDTH (COMMIT_WIDTH),
    .OFF_W        (OFF_W)
  ) u_compactor (
    .lane_valid_i (in_valid),
    .lane_off_o   (lane_off),
    .n_o          (n_commit),
    .trap_off_o   (trap_off)
  );

  // Credit is judged on the start-of-cycle count only; a same-cycle pop frees nothing.
  assign need       = CNT_W'(n_commit) + CNT_W'(in_int_xcpt);
  assign free_slots = CNT_W'(DEPTH) - count_q;
  assign accept     = (need <= free_slots);
  assign pop        = out_valid && out_ready;

  always_comb begin
    for (int i = 0; i < COMMIT_WIDTH; i++) begin
      lane_entry[i]         = '0;
      lane_entry[i].pc      = in_pc[i*XLEN +: XLEN];
      lane_entry[i].inst    = in_inst[i*INST_LEN +: INST_LEN];
      lane_entry[i].wdata   = in_wdata[i*XLEN +: XLEN];
      lane_entry[i].mstatus = in_mstatus[i*XLEN +: XLEN];
      lane_entry[i].check   = in_check[i];
    end
    trap_entry         = '0;
    trap_entry.is_trap = 1'b1;
    trap_entry.cause   = in_cause;
  end

  always_comb begin
    count_d    = count_q + (accept ? need : '0) - CNT_W'(pop);
    wr_d       = wr_q + (accept ? PTR_W'(need) : '0);
    rd_d       = rd_q + PTR_W'(pop);
    overflow_d = overflow_q | ~accept;
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      wr_q       <= '0;
      rd_q       <= '0;
      count_q    <= '0;
      overflow_q <= 1'b0;
      hartid_q   <= '0;
    end else begin
      wr_q       <= wr_d;
      rd_q       <= rd_d;
      count_q    <= count_d;
      overflow_q <= overflow_d;
      hartid_q   <= hartid;
    end
  end

  // Storage needs no reset: the empty-gating below hides stale contents.
  always_ff @(posedge clock) begin
    if (accept) begin
      for (int i = 0; i < COMMIT_WIDTH; i++) begin
        if (in_valid[i]) mem_q[wr_q + PTR_W'(lane_off[i])] <= lane_entry[i];
      end
      if (in_int_xcpt) mem_q[wr_q + PTR_W'(trap_off)] <= trap_entry;
    end
  end

  assign out_valid = (count_q != '0);
  assign head      = out_valid ? mem_q[rd_q] : '0;

  assign out_is_trap = head.is_trap;
  assign out_pc      = head.pc;
  assign out_inst    = head.inst;
  assign out_wdata   = head.wdata;
  assign out_mstatus = head.mstatus;
  assign out_check   = head.check;
  assign out_cause   = head.cause;

  assign out_hartid  = hartid_q;
  assign count       = count_q;
  assign almost_full = (free_slots < CNT_W'(COMMIT_WIDTH + 1));
  assign overflow    = overflow_q;

endmodule

// File: tb/tb_dromajo_trace_queue.sv
// Bench for dromajo_trace_queue: a queue-of-records reference model driven
// cycle by cycle alongside directed and randomized retire bundles.
module tb_dromajo_trace_queue;
  import dromajo_trace_pkg::*;

  localparam int CW    = 3;
  localparam int XL    = 64;
  localparam int DEPTH = 16;
  localparam int EW    = 1 + XL + INST_LEN + XL + XL + 1 + XL;
  localparam int VW    = 1 + EW + HARTID_LEN + 5 + 1 + 1;

  logic                      clock, reset;
  logic [HARTID_LEN-1:0]     hartid;
  logic [CW-1:0]             in_valid, in_check;
  logic [XL*CW-1:0]          in_pc, in_wdata, in_mstatus;
  logic [INST_LEN*CW-1:0]    in_inst;
  logic                      in_int_xcpt;
  logic [XL-1:0]             in_cause;
  logic                      out_valid, out_ready, out_is_trap, out_check;
  logic [XL-1:0]             out_pc, out_wdata, out_mstatus, out_cause;
  logic [INST_LEN-1:0]       out_inst;
  logic [HARTID_LEN-1:0]     out_hartid;
  logic [4:0]                count;
  logic                      almost_full, overflow;

  logic [EW-1:0]         exp_q[$];
  logic                  ovf_m;
  logic [HARTID_LEN-1:0] hartid_m;
  int                    n_tests = 0;
  int                    n_fail  = 0;

  dromajo_trace_queue #(.COMMIT_WIDTH(CW), .XLEN(XL), .DEPTH(DEPTH)) dut (
    .clock(clock), .reset(reset), .hartid(hartid),
    .in_valid(in_valid), .in_pc(in_pc), .in_inst(in_inst), .in_wdata(in_wdata),
    .in_mstatus(in_mstatus), .in_check(in_check), .in_int_xcpt(in_int_xcpt),
    .in_cause(in_cause), .out_valid(out_valid), .out_ready(out_ready),
    .out_is_trap(out_is_trap), .out_pc(out_pc), .out_wdata(out_wdata),
    .out_mstatus(out_mstatus), .out_cause(out_cause), .out_inst(out_inst),
    .out_check(out_check), .out_hartid(out_hartid), .count(count),
    .almost_full(almost_full), .overflow(overflow)
  );

  // ---------------- clock / reset ----------------
  initial clock = 1'b0;
  always #5 clock = ~clock;

  // ---------------- model ----------------
  function automatic logic [VW-1:0] model_vec();
    logic [EW-1:0] head;
    int            sz;
    logic          af;
    sz   = exp_q.size();
    head = (sz != 0) ? exp_q[0] : '0;
    af   = ((DEPTH - sz) < (CW + 1));
    return {(sz != 0), head, hartid_m, 5'(sz), af, ovf_m};
  endfunction

  function automatic logic [VW-1:0] dut_vec();
    return {out_valid, out_is_trap, out_pc, out_inst, out_wdata, out_mstatus,
            out_check, out_cause, out_hartid, count, almost_full, overflow};
  endfunction

  // One clock: the model takes the bundle and pop decision as seen before the edge.
  task automatic tick();
    logic [EW-1:0] push_l[$];
    logic          pop, accept;
    pop = (exp_q.size() != 0) && out_ready;
    for (int i = 0; i < CW; i++)
      if (in_valid[i])
        push_l.push_back({1'b0, in_pc[i*XL +: XL], in_inst[i*INST_LEN +: INST_LEN],
                          in_wdata[i*XL +: XL], in_mstatus[i*XL +: XL], in_check[i], {XL{1'b0}}});
    if (in_int_xcpt)
      push_l.push_back({1'b1, {XL{1'b0}}, {INST_LEN{1'b0}}, {XL{1'b0}}, {XL{1'b0}}, 1'b0, in_cause});
    accept = (push_l.size() <= DEPTH - exp_q.size());
    @(posedge clock);
    if (pop) void'(exp_q.pop_front());
    if (accept) foreach (push_l[j]) exp_q.push_back(push_l[j]);
    else ovf_m = 1'b1;
    hartid_m = hartid;
    #1;
  endtask

  // ---------------- drivers ----------------
  task automatic drive(input logic [CW-1:0] v, input logic x);
    for (int i = 0; i < CW; i++) begin
      in_pc[i*XL +: XL]           = {$urandom, $urandom};
      in_inst[i*INST_LEN +: INST_LEN] = $urandom;
      in_wdata[i*XL +: XL]        = {$urandom, $urandom};
      in_mstatus[i*XL +: XL]      = {$urandom, $urandom};
    end
    in_check    = CW'($urandom);
    in_cause    = {$urandom, $urandom};
    in_valid    = v;
    in_int_xcpt = x;
  endtask

  task automatic idle();
    in_valid    = '0;
    in_int_xcpt = 1'b0;
  endtask

  task automatic apply_reset();
    idle();
    reset = 1'b0;
    exp_q.delete();
    ovf_m    = 1'b0;
    hartid_m = '0;
    @(negedge clock);
    reset = 1'b1;
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    #1;
    n_tests++;
    if (dut_vec() !== model_vec()) begin
      n_fail++; $display("FAIL reset_vec got %h exp %h", dut_vec(), model_vec());
    end
    n_tests++;
    if ({out_valid, count, almost_full, overflow, out_pc} !== '0) begin
      n_fail++; $display("FAIL reset_zero got v=%b cnt=%0d af=%b ov=%b pc=%h exp all 0",
                         out_valid, count, almost_full, overflow, out_pc);
    end
  endtask

  task automatic test_compaction();
    apply_reset();
    out_ready = 1'b1;
    drive(3'b101, 1'b0);
    in_pc[0*XL +: XL] = 64'h8000_0000;
    in_pc[2*XL +: XL] = 64'h8000_0008;
    tick(); idle();
    n_tests++;
    if (out_pc !== 64'h8000_0000 || out_valid !== 1'b1) begin
      n_fail++; $display("FAIL compact_first got v=%b pc=%h exp v=1 pc=80000000", out_valid, out_pc);
    end
    n_tests++;
    if (dut_vec() !== model_vec()) begin
      n_fail++; $display("FAIL compact_vec0 got %h exp %h", dut_vec(), model_vec());
    end
    tick();
    n_tests++;
    if (out_pc !== 64'h8000_0008 || out_valid !== 1'b1) begin
      n_fail++; $display("FAIL compact_second got v=%b pc=%h exp v=1 pc=80000008", out_valid, out_pc);
    end
    tick();
    n_tests++;
    if (out_valid !== 1'b0) begin
      n_fail++; $display("FAIL compact_empty got v=%b exp 0", out_valid);
    end
  endtask

  task automatic test_trap_order();
    logic [XL-1:0] pcs[2];
    apply_reset();
    out_ready = 1'b1;
    drive(3'b011, 1'b1);
    in_cause = 64'h8000_0000_0000_0007;
    pcs[0] = in_pc[0 +: XL];
    pcs[1] = in_pc[XL +: XL];
    tick(); idle();
    for (int k = 0; k < 3; k++) begin
      n_tests++;
      if (dut_vec() !== model_vec()) begin
        n_fail++; $display("FAIL trap_vec%0d got %h exp %h", k, dut_vec(), model_vec());
      end
      n_tests++;
      if (k < 2 && (out_is_trap !== 1'b0 || out_pc !== pcs[k])) begin
        n_fail++; $display("FAIL trap_commit%0d got trap=%b pc=%h exp trap=0 pc=%h", k, out_is_trap, out_pc, pcs[k]);
      end else if (k == 2 && (out_is_trap !== 1'b1 || out_cause !== 64'h8000_0000_0000_0007 || out_pc !== '0)) begin
        n_fail++; $display("FAIL trap_entry got trap=%b cause=%h pc=%h exp 1/8000000000000007/0", out_is_trap, out_cause, out_pc);
      end
      tick();
    end
    n_tests++;
    if (out_valid !== 1'b0) begin
      n_fail++; $display("FAIL trap_empty got v=%b exp 0", out_valid);
    end
  endtask

  task automatic test_fill();
    apply_reset();
    out_ready = 1'b0;
    for (int b = 0; b < 4; b++) begin
      drive(3'b111, 1'b0); tick();
      n_tests++;
      if (count !== 5'(3 * (b + 1)) || almost_full !== 1'b0) begin
        n_fail++; $display("FAIL fill_count%0d got cnt=%0d af=%b exp cnt=%0d af=0", b, count, almost_full, 3 * (b + 1));
      end
    end
    drive(3'b111, 1'b0); tick();
    n_tests++;
    if (count !== 5'd15 || almost_full !== 1'b1 || overflow !== 1'b0) begin
      n_fail++; $display("FAIL fill_15 got cnt=%0d af=%b ov=%b exp 15/1/0", count, almost_full, overflow);
    end
    drive(3'b111, 1'b1); tick();
    n_tests++;
    if (count !== 5'd15 || overflow !== 1'b1) begin
      n_fail++; $display("FAIL fill_reject got cnt=%0d ov=%b exp 15/1", count, overflow);
    end
    idle();
    out_ready = 1'b1;
    for (int k = 0; k < 16; k++) begin
      n_tests++;
      if (dut_vec() !== model_vec()) begin
        n_fail++; $display("FAIL fill_drain%0d got %h exp %h", k, dut_vec(), model_vec());
      end
      tick();
    end
  endtask

  task automatic test_no_credit();
    apply_reset();
    out_ready = 1'b0;
    for (int b = 0; b < 5; b++) begin drive(3'b111, 1'b0); tick(); end
    out_ready = 1'b1;
    drive(3'b001, 1'b0); tick();
    n_tests++;
    if (count !== 5'd15 || overflow !== 1'b0) begin
      n_fail++; $display("FAIL credit_need1 got cnt=%0d ov=%b exp 15/0", count, overflow);
    end
    drive(3'b011, 1'b0); tick();
    n_tests++;
    if (count !== 5'd14 || overflow !== 1'b1) begin
      n_fail++; $display("FAIL credit_need2 got cnt=%0d ov=%b exp 14/1", count, overflow);
    end
    n_tests++;
    if (dut_vec() !== model_vec()) begin
      n_fail++; $display("FAIL credit_vec got %h exp %h", dut_vec(), model_vec());
    end
    idle();
  endtask

  task automatic test_wrap();
    int k = 0, popped = 0, cyc = 0, lane;
    apply_reset();
    while (popped < 40 && cyc < 400) begin
      out_ready = (cyc % 2 == 0);
      if (k < 40 && exp_q.size() < DEPTH - 1) begin
        lane = $urandom_range(0, CW - 1);
        drive(CW'(1) << lane, 1'b0);
        in_pc[lane*XL +: XL] = 64'(4 * k);
        k++;
      end else idle();
      if (out_valid && out_ready) begin
        n_tests++;
        if (out_pc !== 64'(4 * popped)) begin
          n_fail++; $display("FAIL wrap_pop%0d got pc=%h exp %h", popped, out_pc, 64'(4 * popped));
        end
        popped++;
      end
      tick();
      n_tests++;
      if (dut_vec() !== model_vec()) begin
        n_fail++; $display("FAIL wrap_vec cyc %0d got %h exp %h", cyc, dut_vec(), model_vec());
      end
      cyc++;
    end
    idle();
    n_tests++;
    if (popped != 40 || overflow !== 1'b0) begin
      n_fail++; $display("FAIL wrap_total got pops=%0d ov=%b exp 40/0", popped, overflow);
    end
  endtask

  task automatic test_async_reset();
    apply_reset();
    out_ready = 1'b0;
    for (int b = 0; b < 5; b++) begin drive(3'b111, 1'b0); tick(); end
    drive(3'b111, 1'b1); tick();
    idle();
    out_ready = 1'b1;
    for (int b = 0; b < 8; b++) tick();
    out_ready = 1'b0;
    n_tests++;
    if (count !== 5'd7 || overflow !== 1'b1) begin
      n_fail++; $display("FAIL areset_pre got cnt=%0d ov=%b exp 7/1", count, overflow);
    end
    #2;
    reset = 1'b0;
    drive(3'b111, 1'b1);
    exp_q.delete(); ovf_m = 1'b0; hartid_m = '0;
    #1;
    n_tests++;
    if (count !== 5'd0 || out_valid !== 1'b0 || overflow !== 1'b0) begin
      n_fail++; $display("FAIL areset_now got cnt=%0d v=%b ov=%b exp 0/0/0", count, out_valid, overflow);
    end
    @(posedge clock); #1;
    n_tests++;
    if (dut_vec() !== model_vec()) begin
      n_fail++; $display("FAIL areset_hold got %h exp %h", dut_vec(), model_vec());
    end
    @(negedge clock);
    reset = 1'b1;
    out_ready = 1'b1;
    drive(3'b110, 1'b0);
    tick(); idle();
    for (int k = 0; k < 3; k++) begin
      n_tests++;
      if (dut_vec() !== model_vec()) begin
        n_fail++; $display("FAIL areset_after%0d got %h exp %h", k, dut_vec(), model_vec());
      end
      tick();
    end
  endtask

  task automatic test_random();
    apply_reset();
    for (int c = 0; c < 600; c++) begin
      if (c % 50 == 0) hartid = $urandom;
      out_ready = (c < 150) ? ($urandom_range(0, 3) == 0) : ($urandom_range(0, 3) != 0);
      drive(CW'($urandom), $urandom_range(0, 5) == 0);
      if (c == 300) begin apply_reset(); drive(CW'($urandom), 1'b0); end
      tick();
      n_tests++;
      if (dut_vec() !== model_vec()) begin
        n_fail++; $display("FAIL random cyc %0d got %h exp %h", c, dut_vec(), model_vec());
      end
    end
    idle();
  endtask

  // ---------------- sequence and report ----------------
  initial begin
    reset = 1'b0;
    hartid = 32'hC0DE_0001;
    out_ready = 1'b0;
    in_pc = '0; in_inst = '0; in_wdata = '0; in_mstatus = '0;
    in_check = '0; in_cause = '0;
    idle();
    exp_q.delete(); ovf_m = 1'b0; hartid_m = '0;
    test_reset();
    test_compaction();
    test_trap_order();
    test_fill();
    test_no_credit();
    test_wrap();
    test_async_reset();
    test_random();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
